// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the user UART block (transmitter and receiver).
//   DATA_BITS    : data bits per frame (8)
//   START_LEVEL  : line level driven during the start bit
//   STOP_LEVEL   : line level driven during the stop bit
//   IDLE_LEVEL   : line level between frames
//   uart_state_t : 3-bit state encoding shared by tx and rx controllers
//   clamp_div()  : turns a raw clk_div value into a usable bit period
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // One encoding for both directions so waveforms read the same on tx and rx.
    // PARITY is only visited when the parity option is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } uart_state_t;

    // A divisor of zero would give a zero-length bit; treat it as one cycle.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Loadable bit-period counter. On load it captures the bit period and starts
// counting from zero; while running it counts 0..div-1 and wraps, flagging
// the last cycle of every bit.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : capture div and restart the count at zero
//   run        : advance the count this cycle
//   div        : bit period in clock cycles (caller supplies a value >= 1)
//   bit_tick   : high on the last cycle of each bit while running
// ---------------------------------------------------------------------------
module uart_bit_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        run,
    input  logic [31:0] div,
    output logic        bit_tick
);

    logic [31:0] div_q;
    logic [31:0] cnt;
    logic        at_last;

    assign at_last  = (cnt == div_q - 32'd1);
    assign bit_tick = run && at_last;

    // The divisor is held privately so a caller changing div mid-frame
    // cannot stretch or shrink the bit currently on the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 32'd0;
            cnt   <= 32'd0;
        end else if (load) begin
            div_q <= div;
            cnt   <= 32'd0;
        end else if (run) begin
            if (at_last) begin
                cnt <= 32'd0;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/uart_transmit.sv
// ---------------------------------------------------------------------------
// uart_transmit
// Serialises one byte per request: start bit, DATA_BITS data bits LSB first,
// optional even parity bit, one stop bit. Each bit lasts max(clk_div,1) cycles.
//   clk, rst_n    : clock and asynchronous active-low reset
//   clk_div       : clock cycles per bit (0 behaves as 1), latched at accept
//   tx_start      : send request, accepted in IDLE (and in DONE, see below)
//   tx_data       : byte to send, latched at accept
//   tx            : registered serial line, idle high
//   busy          : high while start/data/parity/stop bits are on the line
//   o_byte_finish : one-cycle pulse after the stop bit
//   tx_ready      : high in IDLE, where a request will be accepted
// Build option: define UART_TX_PARITY_EN to insert an even parity bit
// between the last data bit and the stop bit (11-bit frame).
// ---------------------------------------------------------------------------
module uart_transmit #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          clk_div,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 o_byte_finish,
    output logic                 tx_ready
);

    import uart_pkg::*;

    localparam int                IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    uart_state_t          state, next_state;
    logic [DATA_BITS-1:0] shift, next_shift;
    logic [IDX_W-1:0]     bit_idx, next_idx;
    logic                 tx_next;
    logic                 timer_load;
    logic                 timer_run;
    logic                 bit_tick;

    uart_bit_timer u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .run      (timer_run),
        .div      (clamp_div(clk_div)),
        .bit_tick (bit_tick)
    );

    assign timer_run     = (state == ST_START) || (state == ST_DATA) ||
                           (state == ST_PARITY) || (state == ST_STOP);
    assign busy          = timer_run;
    assign tx_ready      = (state == ST_IDLE);
    assign o_byte_finish = (state == ST_DONE);

    // State, frame data and the serial line all move together, so tx always
    // shows the level belonging to the state just entered. Reset drives the
    // line high immediately, aborting any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= IDLE_LEVEL;
        end else begin
            state   <= next_state;
            shift   <= next_shift;
            bit_idx <= next_idx;
            tx      <= tx_next;
        end
    end

    // Frame sequencing. DONE hands straight over to a pending request so a
    // held tx_start produces frames exactly 10*D+1 cycles apart, with the
    // single DONE cycle as the only gap. The line level for the next cycle
    // is derived from the next state so it is ready to be registered.
    always_comb begin
        next_state = state;
        next_shift = shift;
        next_idx   = bit_idx;
        timer_load = 1'b0;
        tx_next    = IDLE_LEVEL;

        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    next_state = ST_START;
                    next_shift = tx_data;
                    next_idx   = '0;
                    timer_load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    next_state = ST_DATA;
                    next_idx   = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        next_state = ST_PARITY;
`else
                        next_state = ST_STOP;
`endif
                    end else begin
                        next_idx = bit_idx + ONE_IDX;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (tx_start) begin
                    next_state = ST_START;
                    next_shift = tx_data;
                    next_idx   = '0;
                    timer_load = 1'b1;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_shift = '0;
                next_idx   = '0;
            end
        endcase

        case (next_state)
            ST_START:  tx_next = START_LEVEL;
            ST_DATA:   tx_next = next_shift[next_idx];
            ST_PARITY: tx_next = ^next_shift;
            default:   tx_next = STOP_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_transmit.sv
// ---------------------------------------------------------------------------
// tb_uart_transmit
// Bench for uart_transmit. Each request pushes its expected frame into a
// scoreboard queue; a monitor decodes the serial line independently and
// compares every bit level, bit duration, busy, the finish pulse and the
// spacing between frame starts. Honours UART_TX_PARITY_EN like the design.
// ---------------------------------------------------------------------------
module tb_uart_transmit;

    typedef struct {
        logic [7:0] data;
        int         bit_len;
        logic       parity;
        int         gap;
        bit         abort_exp;
    } frame_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] clk_div;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx;
    logic        busy;
    logic        o_byte_finish;
    logic        tx_ready;

    frame_t sb[$];
    int     checks_total  = 0;
    int     checks_passed = 0;
    int     cycle         = 0;
    int     last_start    = 0;
    int     frame_no      = 0;

    uart_transmit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_div       (clk_div),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx            (tx),
        .busy          (busy),
        .o_byte_finish (o_byte_finish),
        .tx_ready      (tx_ready)
    );

    // Free-running clock and a cycle count used to measure frame spacing.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    // Hard stop in case something wedges the bench itself.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic record_fail(input string name, input string what);
        checks_total++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    // Queues the expected frame, then presents a one-cycle request. Called on
    // a negedge; the following posedge is the accepting edge E0.
    task automatic applyStimulus(input logic [7:0] data, input logic [31:0] div,
                                 input int bit_len, input logic parity,
                                 input int gap, input bit abort_exp);
        frame_t e;
        e.data      = data;
        e.bit_len   = bit_len;
        e.parity    = parity;
        e.gap       = gap;
        e.abort_exp = abort_exp;
        sb.push_back(e);
        clk_div  = div;
        tx_data  = data;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Waits for the monitor to retire every queued frame, within a budget.
    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            record_fail("drain_timeout", $sformatf("%0d frames still queued, expected 0", sb.size()));
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Decodes one frame whose start bit was seen on the current negedge.
    task automatic monitor_frame();
        frame_t e;
        logic   bits [0:10];
        int     nbits;
        bit     aborted;
        bit     level_ok;
        bit     busy_ok;

        if (sb.size() == 0) begin
            record_fail("unexpected_frame", "start bit seen with no request outstanding");
            while (tx === 1'b0) @(negedge clk);
            return;
        end
        e = sb[0];
        frame_no++;
        if (e.gap != 0) begin
            checkOutput($sformatf("frame%0d_start_gap", frame_no), cycle - last_start, e.gap);
        end
        last_start = cycle;

        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k + 1] = e.data[k];
`ifdef UART_TX_PARITY_EN
        bits[9]  = e.parity;
        bits[10] = 1'b1;
        nbits    = 11;
`else
        bits[9]  = 1'b1;
        bits[10] = 1'b1;
        nbits    = 10;
`endif

        aborted = 1'b0;
        busy_ok = 1'b1;
        for (int b = 0; b < nbits && !aborted; b++) begin
            level_ok = 1'b1;
            for (int s = 0; s < e.bit_len; s++) begin
                if (b != 0 || s != 0) @(negedge clk);
                if (rst_n !== 1'b1) begin
                    aborted = 1'b1;
                    break;
                end
                if (tx !== bits[b]) level_ok = 1'b0;
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
            if (!aborted) begin
                checkOutput($sformatf("frame%0d_bit%0d_level", frame_no, b), int'(level_ok), 1);
            end
        end

        if (aborted) begin
            checkOutput($sformatf("frame%0d_aborted", frame_no), 1, int'(e.abort_exp));
            void'(sb.pop_front());
            while (rst_n !== 1'b1) @(negedge clk);
            return;
        end

        checkOutput($sformatf("frame%0d_busy_during", frame_no), int'(busy_ok), 1);
        @(negedge clk);
        checkOutput($sformatf("frame%0d_finish", frame_no), int'(o_byte_finish), 1);
        checkOutput($sformatf("frame%0d_busy_done", frame_no), int'(busy), 0);
        checkOutput($sformatf("frame%0d_ready_done", frame_no), int'(tx_ready), 0);
        checkOutput($sformatf("frame%0d_tx_done", frame_no), int'(tx), 1);
        if (e.abort_exp) record_fail($sformatf("frame%0d_aborted", frame_no), "frame completed, expected abort");
        void'(sb.pop_front());
    endtask

    // Monitor: watches the line every negedge, flags stray finish pulses and
    // hands each start bit to the frame decoder.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (o_byte_finish !== 1'b0) begin
                    record_fail("spurious_finish", "o_byte_finish high outside a frame end, expected 0");
                end
                if (tx === 1'b0) monitor_frame();
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        rst_n    = 1'b0;
        clk_div  = 32'd4;
        tx_start = 1'b0;
        tx_data  = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("reset_tx", int'(tx), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_finish", int'(o_byte_finish), 0);
        checkOutput("reset_ready", int'(tx_ready), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 0xA5 frame; a request at E0+12 with new data and divisor
        // must be ignored without disturbing the frame in flight.
        $display("[TB] basic frame with ignored mid-frame request");
        applyStimulus(8'hA5, 32'd4, 4, 1'b0, 0, 1'b0);
        repeat (11) @(negedge clk);
        checkOutput("ignored_req_ready", int'(tx_ready), 0);
        checkOutput("ignored_req_busy", int'(busy), 1);
        tx_start = 1'b1;
        tx_data  = 8'hFF;
        clk_div  = 32'd1;
        @(negedge clk);
        tx_start = 1'b0;
        clk_div  = 32'd4;
        wait_drain(200);
        repeat (30) @(negedge clk);
        checkOutput("idle_ready", int'(tx_ready), 1);

        // Divisor clamp: 0 and 1 both give one-cycle bits.
        $display("[TB] divisor clamp");
        applyStimulus(8'h3C, 32'd0, 1, 1'b0, 0, 1'b0);
        wait_drain(100);
        applyStimulus(8'h3C, 32'd1, 1, 1'b0, 0, 1'b0);
        wait_drain(100);

        // Back-to-back with tx_start held: second frame starts 21 cycles
        // after the first; data switches to 0xFF before the second accept.
        $display("[TB] back-to-back frames");
        begin
            frame_t e;
            e.bit_len   = 2;
            e.parity    = 1'b0;
            e.abort_exp = 1'b0;
            e.data      = 8'h00;
            e.gap       = 0;
            sb.push_back(e);
            e.data      = 8'hFF;
`ifdef UART_TX_PARITY_EN
            e.gap       = 23;
`else
            e.gap       = 21;
`endif
            sb.push_back(e);
        end
        clk_div  = 32'd2;
        tx_data  = 8'h00;
        tx_start = 1'b1;
        repeat (10) @(negedge clk);
        tx_data  = 8'hFF;
        repeat (20) @(negedge clk);
        tx_start = 1'b0;
        wait_drain(200);

        // Reset during data bit 3 of 0xC3 (bit 3 is 0, so tx visibly rises).
        $display("[TB] reset mid-frame");
        applyStimulus(8'hC3, 32'd4, 4, 1'b0, 0, 1'b1);
        repeat (16) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_tx", int'(tx), 1);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_finish", int'(o_byte_finish), 0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        wait_drain(50);
        applyStimulus(8'hC3, 32'd4, 4, 1'b0, 0, 1'b0);
        wait_drain(200);

        // Receiver-style byte set at D=8; 0x07 is the odd-weight parity case.
        $display("[TB] byte set at divisor 8");
        applyStimulus(8'h00, 32'd8, 8, 1'b0, 0, 1'b0);
        wait_drain(300);
        applyStimulus(8'h55, 32'd8, 8, 1'b0, 0, 1'b0);
        wait_drain(300);
        applyStimulus(8'hAA, 32'd8, 8, 1'b0, 0, 1'b0);
        wait_drain(300);
        applyStimulus(8'hFF, 32'd8, 8, 1'b0, 0, 1'b0);
        wait_drain(300);
        applyStimulus(8'h81, 32'd8, 8, 1'b0, 0, 1'b0);
        wait_drain(300);
        applyStimulus(8'h07, 32'd8, 8, 1'b1, 0, 1'b0);
        wait_drain(300);

        repeat (20) @(negedge clk);
        checkOutput("final_queue_empty", sb.size(), 0);
        checkOutput("final_ready", int'(tx_ready), 1);
        checkOutput("frames_seen", frame_no, 13);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
